// File: rtl/ahfp_round_pipe_if.sv
// Valid/ready stream bundle for the ahfp round-to-integral pipe.
// The operand stream comes in and the rounded-result stream goes out.
interface ahfp_round_pipe_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [1:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_inexact;

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_inexact
   );

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_inexact
   );
endinterface

// File: rtl/ahfp_round_pipe.sv
// Two-stage IEEE-754 round-to-integral unit (floor/ceil/trunc/RNE) on valid/ready streams.
// S1 classifies, clears the fraction and decides the increment; S2 adds the increment.
module ahfp_round_pipe #(
   parameter int unsigned EXP_W     = 8,
   parameter int unsigned MAN_W     = 23,
   parameter bit          CLAMP_NEG = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   ahfp_round_pipe_if.slave bus
);
   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned MAG_W = EXP_W + MAN_W;
   localparam int unsigned BIAS  = 2**(EXP_W-1) - 1;

   logic             w_sign;
   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_man;
   logic [MAG_W-1:0] w_mag;
   logic             w_nan;
   int               w_e;
   int               w_sh;
   logic [MAN_W:0]   w_unit;
   logic [MAN_W-1:0] w_mask;
   logic [MAN_W:0]   w_gl;
   logic             w_frac;
   logic             w_sticky;
   logic             w_inc;
   logic [MAG_W-1:0] w_one;
   logic             w_s1_sign;
   logic [MAG_W-1:0] w_s1_mag;
   logic [MAG_W-1:0] w_s1_add;
   logic             w_s1_inex;
   logic             w_s1_adv;
   logic             w_in_ready;

   logic             r_s1_valid;
   logic             r_s1_sign;
   logic [MAG_W-1:0] r_s1_mag;
   logic [MAG_W-1:0] r_s1_add;
   logic             r_s1_inex;
   logic             r_out_valid;
   logic [W-1:0]     r_out_data;
   logic             r_out_inex;

   assign w_s1_adv   = !r_out_valid || bus.out_ready;
   assign w_in_ready = !r_s1_valid || w_s1_adv;

   // S1: classify operand, clear fraction bits, choose the addend
   always_comb begin
      w_sign    = bus.in_data[W-1];
      w_exp     = bus.in_data[W-2 -: EXP_W];
      w_man     = bus.in_data[MAN_W-1:0];
      w_mag     = bus.in_data[MAG_W-1:0];
      w_nan     = (&w_exp) && (|w_man);
      w_e       = int'(w_exp) - int'(BIAS);
      w_sh      = int'(MAN_W) - w_e;
      w_unit    = (MAN_W+1)'(1) << w_sh;
      w_mask    = MAN_W'(w_unit - (MAN_W+1)'(1));
      w_gl      = {1'b1, w_man} >> (w_sh - 1);
      w_frac    = |(w_man & w_mask);
      w_sticky  = |(w_man & (w_mask >> 1));
      w_one     = {EXP_W'(BIAS), MAN_W'(0)};
      w_inc     = 1'b0;
      w_s1_sign = w_sign;
      w_s1_mag  = w_mag;
      w_s1_add  = '0;
      w_s1_inex = 1'b0;

      if (CLAMP_NEG && w_sign && !w_nan) begin
         w_s1_sign = 1'b0;
         w_s1_mag  = '0;
         w_s1_inex = |w_mag;
      end else if ((&w_exp) || (w_e >= int'(MAN_W))) begin
         w_s1_mag = w_mag;
      end else if (w_e < 0) begin
         // |x| < 1: result magnitude is either 0 or exactly 1.0
         w_frac    = |w_mag;
         w_s1_mag  = '0;
         w_s1_inex = w_frac;
         case (bus.in_mode)
            2'b00:   w_inc = w_sign & w_frac;
            2'b01:   w_inc = !w_sign & w_frac;
            2'b10:   w_inc = 1'b0;
            default: w_inc = (w_e == -1) && (|w_man);
         endcase
         w_s1_add = w_inc ? w_one : '0;
      end else begin
         case (bus.in_mode)
            2'b00:   w_inc = w_sign & w_frac;
            2'b01:   w_inc = !w_sign & w_frac;
            2'b10:   w_inc = 1'b0;
            default: w_inc = w_gl[0] & (w_sticky | w_gl[1]);
         endcase
         w_s1_mag  = w_mag & ~{EXP_W'(0), w_mask};
         w_s1_add  = w_inc ? MAG_W'(w_unit) : '0;
         w_s1_inex = w_frac;
      end
   end

   // Pipeline registers; carry out of the mantissa rolls into the exponent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_mag    <= '0;
         r_s1_add    <= '0;
         r_s1_inex   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_inex  <= 1'b0;
      end else begin
         if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_sign <= w_s1_sign;
               r_s1_mag  <= w_s1_mag;
               r_s1_add  <= w_s1_add;
               r_s1_inex <= w_s1_inex;
            end
         end
         if (w_s1_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data <= {r_s1_sign, r_s1_mag + r_s1_add};
               r_out_inex <= r_s1_inex;
            end
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.out_inexact = r_out_inex;
endmodule
